fmamul_seq: RTL and testbench

- Iterative significand multiplier that produces the product operand consumed by fmaadd: p_sign, p_exp, p_fract, plus the x_zero and y_zero kill flags.
- It is the upstream end of the product interface that the add/normalize stage consumes.
- Half-precision by default, with radix-2 shift-and-add using one multiplier bit per cycle.
- Uses a valid/ready handshake on both sides so the datapath can be shared in area-constrained fma16 builds.

---
 rtl/fma_pkg.sv | 17 +
 rtl/fmamul_seq.sv | 126 ++++++++++++
 tb/tb_fmamul_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared types and default widths for the fma16 multiply/add slice.
package fma_pkg;

  localparam int FMA_NF = 10;
  localparam int FMA_NE = 5;
  localparam int BIAS   = 2**(FMA_NE-1) - 1;
  localparam int SIG_W  = FMA_NF + 1;
  localparam int PROD_W = 2*FMA_NF + 2;
  localparam int PEXP_W = FMA_NE + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fmamul_seq.sv
// Radix-2 shift-and-add significand multiplier feeding fmaadd; NF+3 cycles per op, no overlap.
// FMAMUL_EARLY_ZERO_EN: zero operands bypass the iteration and return p_fract=0 after 2 cycles.
module fmamul_seq
  import fma_pkg::*;
#(
  parameter int NF = FMA_NF,
  parameter int NE = FMA_NE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NE+NF:0]      x,
  input  logic [NE+NF:0]      y,
  input  logic                mul,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                p_sign,
  output logic [NE+1:0]       p_exp,
  output logic [2*NF+1:0]     p_fract,
  output logic                x_zero,
  output logic                y_zero
);

  localparam int SW = NF + 1;
  localparam int PW = 2*NF + 2;
  localparam int EW = NE + 2;
  localparam int CW = $clog2(NF + 1);
  localparam logic [EW-1:0] EBIAS = EW'(2**(NE-1) - 1);

  state_t          r_state;
  logic [SW-1:0]   r_mcand;
  logic [SW-1:0]   r_mplier;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_pend;
  logic            r_out_vld;
  logic            r_sign;
  logic [EW-1:0]   r_exp;
  logic [PW-1:0]   r_fract;
  logic            r_xz;
  logic            r_yz;

  logic            w_xz;
  logic            w_yz;
  logic            w_skip;
  logic [EW-1:0]   w_yexp;
  logic [SW-1:0]   w_mplier;
  logic [PW-1:0]   w_addend;

  assign w_xz     = (x[NE+NF-1:0] == '0);
  assign w_yz     = mul & (y[NE+NF-1:0] == '0);
  assign w_yexp   = mul ? {2'b00, y[NE+NF-1:NF]} : EBIAS;
  assign w_mplier = mul ? {1'b1, y[NF-1:0]} : {1'b1, {NF{1'b0}}};
  assign w_addend = r_mplier[r_cnt] ? (PW'(r_mcand) << r_cnt) : '0;

`ifdef FMAMUL_EARLY_ZERO_EN
  assign w_skip = w_xz | w_yz;
`else
  assign w_skip = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_vld;
  assign p_sign    = r_sign;
  assign p_exp     = r_exp;
  assign p_fract   = r_fract;
  assign x_zero    = r_xz;
  assign y_zero    = r_yz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_pend    <= 1'b0;
      r_out_vld <= 1'b0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_fract   <= '0;
      r_xz      <= 1'b0;
      r_yz      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= {1'b1, x[NF-1:0]};
            r_mplier <= w_mplier;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_sign   <= x[NE+NF] ^ (mul & y[NE+NF]);
            r_exp    <= {2'b00, x[NE+NF-1:NF]} + w_yexp - EBIAS;
            r_xz     <= w_xz;
            r_yz     <= w_yz;
            r_state  <= w_skip ? DONE : MUL;
          end
        end
        MUL: begin
          r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(NF)) r_state <= DONE;
        end
        DONE: begin
          // Capture the accumulator first, raise out_valid one cycle later.
          if (r_out_vld) begin
            if (out_ready) begin
              r_out_vld <= 1'b0;
              r_state   <= IDLE;
            end
          end else if (r_pend) begin
            r_out_vld <= 1'b1;
            r_pend    <= 1'b0;
          end else begin
            r_fract <= r_acc;
            r_pend  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmamul_seq.sv
// Randomized and directed bench for fmamul_seq against a plain-arithmetic product model.
module tb_fmamul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        mul;
  logic        out_valid;
  logic        out_ready;
  logic        p_sign;
  logic [6:0]  p_exp;
  logic [21:0] p_fract;
  logic        x_zero;
  logic        y_zero;

  fmamul_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .mul(mul), .out_valid(out_valid), .out_ready(out_ready),
    .p_sign(p_sign), .p_exp(p_exp), .p_fract(p_fract),
    .x_zero(x_zero), .y_zero(y_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] fract;
    logic [6:0]  exp;
    logic        sign;
    logic        xz;
    logic        yz;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t pin;
  bit   hs_prev = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out", nm);
  endtask

  function automatic exp_t model(input logic [15:0] xv, input logic [15:0] yv, input logic mv);
    exp_t r;
    int mx, my, ex;
    mx = 1024 + int'(xv[9:0]);
    my = mv ? 1024 + int'(yv[9:0]) : 1024;
    ex = int'(xv[14:10]) + (mv ? int'(yv[14:10]) : 15) - 15;
    r.sign  = xv[15] ^ (mv & yv[15]);
    r.exp   = 7'(ex);
    r.xz    = (xv[14:0] == 15'd0);
    r.yz    = mv && (yv[14:0] == 15'd0);
    r.fract = 22'(mx * my);
    r.lat   = 13;
`ifdef FMAMUL_EARLY_ZERO_EN
    if (r.xz || r.yz) begin
      r.fract = '0;
      r.lat   = 2;
    end
`endif
    r.acc  = 0;
    r.seen = 0;
    return r;
  endfunction

  // Accept monitor: every handshake on the input side enqueues an expectation.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset && in_valid && in_ready) begin
      mon_e = model(x, y, mul);
      mon_e.acc = cyc;
      sb.push_back(mon_e);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (hs_prev) begin
        chk("in_ready_after_hs", in_ready, 1);
        chk("out_valid_after_hs", out_valid, 0);
      end
      hs_prev = 0;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_out_valid actual=1 expected=0");
        end else begin
          if (!sb[0].seen) begin
            chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            sb[0].seen = 1;
          end
          chk("p_fract", p_fract, sb[0].fract);
          chk("p_exp", p_exp, sb[0].exp);
          chk("p_sign", p_sign, sb[0].sign);
          chk("x_zero", x_zero, sb[0].xz);
          chk("y_zero", y_zero, sb[0].yz);
          chk("in_ready_busy", in_ready, 0);
          if (out_ready) begin
            void'(sb.pop_front());
            hs_prev = 1;
          end
        end
      end else if (sb.size() > 0 && (cyc - sb[0].acc) > 60) begin
        fail_now("result_wait");
        void'(sb.pop_front());
      end
    end
  end

  task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic mv, input bit rr);
    bit got;
    got = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x = xv;
    y = yv;
    mul = mv;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
      end else begin
        @(posedge clk);
        #1;
        if (rr) out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    if (!got) fail_now("accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1;
    end
    if (!done) fail_now("drain");
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_p_fract"}, p_fract, 0);
    chk({tag, "_p_exp"}, p_exp, 0);
    chk({tag, "_p_sign"}, p_sign, 0);
    chk({tag, "_zero_flags"}, {x_zero, y_zero}, 0);
  endtask

  initial begin
    logic [15:0] rx, ry;
    bit got;

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    mul = 1'b0;

    // Hand-computed anchors for the model.
    pin = model(16'h3E00, 16'h4000, 1'b1);
    chk("model_1p5x2_fract", pin.fract, 22'h180000);
    chk("model_1p5x2_exp", pin.exp, 7'd16);
    pin = model(16'h3E00, 16'h3E00, 1'b1);
    chk("model_1p5sq_fract", pin.fract, 22'h240000);
    pin = model(16'hBC00, 16'h3C00, 1'b1);
    chk("model_neg_sign_exp", {pin.sign, pin.exp}, {1'b1, 7'd15});
    pin = model(16'h3E00, 16'hFFFF, 1'b0);
    chk("model_addonly", {pin.sign, pin.exp, pin.fract}, {1'b0, 7'd15, 22'h180000});

    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors.
    send(16'h3E00, 16'h4000, 1'b1, 0);
    send(16'h3E00, 16'h3E00, 1'b1, 0);
    send(16'hBC00, 16'h3C00, 1'b1, 0);
    send(16'h3E00, 16'hFFFF, 1'b0, 0);
    send(16'h0000, 16'h4000, 1'b1, 0);
    send(16'h3C00, 16'h8000, 1'b1, 0);
    send(16'h3C00, 16'h0000, 1'b0, 0);
    send(16'h7BFF, 16'h7BFF, 1'b1, 0);
    drain();

    // Back-pressure: hold the result, offer a new op that must wait.
    out_ready = 1'b0;
    send(16'h3E00, 16'h4000, 1'b1, 0);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) fail_now("bp_out_valid");
    in_valid = 1'b1;
    x = 16'h4200;
    y = 16'hC100;
    mul = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h4200, 16'hC100, 1'b1, 0);
    drain();

    // Reset in the middle of the iteration, then a clean op.
    send(16'h3E00, 16'h4000, 1'b1, 0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    hs_prev = 0;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(16'h3E00, 16'h4000, 1'b1, 0);
    drain();

    // Random operands with random output back-pressure.
    for (int n = 0; n < 40; n++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rx[14:0] = '0;
      if ($urandom_range(0, 5) == 0) ry[14:0] = '0;
      send(rx, ry, 1'($urandom_range(0, 1)), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
